// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// SIPO_PARITY_EN adds the PARITY state for a trailing even-parity bit.
package sipo_pkg;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT
`ifdef SIPO_PARITY_EN
      , PARITY
`endif
   } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts data bits received for the current word; term flags that the
// next increment would complete the word.
module sipo_bit_counter #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic term
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear wins so a flush landing on a counted bit still empties the count.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign term = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a one-word output buffer and overrun pulse.
// Optional SIPO_PARITY_EN: a trailing even-parity bit per word, reported on par_err.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             dir,
   input  logic             flush,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             overrun,
   output logic             par_err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;

   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_term;
   logic             word_done;
   logic [WIDTH-1:0] word_val;
   logic [WIDTH-1:0] shifted;

`ifdef SIPO_PARITY_EN
   logic             par_err_q, par_err_d;
   logic             word_perr;
`endif

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b,
                                                  input logic d);
      if (d == DIR_MSB_FIRST) begin
         return {cur[WIDTH-2:0], b};
      end
      return {b, cur[WIDTH-1:1]};
   endfunction

   sipo_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .term (cnt_term)
   );

   // Word assembly: the direction is latched on the first bit and used for the whole word.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      sr_d      = sr_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      word_done = 1'b0;
      word_val  = sr_q;
      shifted   = shift_in(sr_q, sin, dir_q);
`ifdef SIPO_PARITY_EN
      word_perr = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (sin_valid) begin
               dir_d   = dir;
               sr_d    = shift_in('0, sin, dir);
               cnt_inc = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               sr_d = shifted;
               if (cnt_term) begin
                  cnt_clr = 1'b1;
`ifdef SIPO_PARITY_EN
                  state_d = PARITY;
`else
                  state_d   = IDLE;
                  word_done = 1'b1;
                  word_val  = shifted;
                  sr_d      = '0;
`endif
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
`ifdef SIPO_PARITY_EN
         PARITY: begin
            if (sin_valid) begin
               state_d   = IDLE;
               word_done = 1'b1;
               word_val  = sr_q;
               word_perr = ^{sr_q, sin};
               sr_d      = '0;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         state_d   = IDLE;
         sr_d      = '0;
         cnt_clr   = 1'b1;
         cnt_inc   = 1'b0;
         word_done = 1'b0;
      end
   end

   // Output buffer. Handshake: a word moves downstream on any edge where
   // dout_valid and dout_ready are both high; dout is stable while dout_valid
   // is high and dout_ready is low. A word completing into a full, unconsumed
   // buffer is dropped and flagged on overrun the following cycle.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_d    = par_err_q;
`endif
      if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
      if (word_done) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = word_val;
            dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
            par_err_d    = word_perr;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dir_q        <= DIR_LSB_FIRST;
         sr_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
         par_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         sr_q         <= sr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
         par_err_q    <= par_err_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
   assign par_err    = par_err_q;
`else
   assign par_err    = 1'b0;
`endif

endmodule
